truth_table_capture: RTL and testbench

//  Reads a logic gate back into its truth-table ID. It is the reverse of the
//  per-ID gate modules, which map an ID to a function; this block maps a

---
 rtl/truth_table_capture.sv | 126 ++++++++++++
 tb/tb_truth_table_capture.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_capture.sv
// truth_table_capture: steps a combinational function through every input row and
// packs the sampled outputs into its hex truth-table ID. Optional: TT_GLITCH_CHECK_EN.
module truth_table_capture #(
   parameter int N_IN   = 3,
   parameter int SETTLE = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic [N_IN-1:0]       probe,
   input  logic                  sample_in,
   output logic                  busy,
   output logic                  done,
   output logic [(2**N_IN)-1:0]  table_out
`ifdef TT_GLITCH_CHECK_EN
   ,
   output logic                  unstable
`endif
);

   localparam int TW = 2**N_IN;
   localparam int RW = N_IN + 1;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   // state  | meaning
   // IDLE   | waiting for start
   // SETTLE | probe held, letting the function output settle
   // SAMPLE | capture sample_in into the current row's table bit
   // FIN    | one-cycle done pulse
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SAMPLE = 2'd2,
      S_FIN    = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [RW-1:0]   row_q;
   logic [CW-1:0]   cnt_q;
   logic [TW-1:0]   table_q;
   logic            last_settle;
   logic            last_row;

   assign last_settle = (cnt_q == CW'(SETTLE - 1));
   assign last_row    = (row_q == RW'(TW - 1));

   // The probe is the row index itself; it parks on the last row until the next start.
   assign probe     = row_q[N_IN-1:0];
   assign table_out = table_q;

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_SETTLE;
         end
         S_SETTLE: begin
            busy = 1'b1;
            if (last_settle) state_d = S_SAMPLE;
         end
         S_SAMPLE: begin
            busy    = 1'b1;
            state_d = last_row ? S_FIN : S_SETTLE;
         end
         S_FIN: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef TT_GLITCH_CHECK_EN
   logic pre_q;
   logic unstable_q;
   assign unstable = unstable_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         cnt_q   <= '0;
         table_q <= '0;
`ifdef TT_GLITCH_CHECK_EN
         pre_q      <= 1'b0;
         unstable_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  row_q   <= '0;
                  cnt_q   <= '0;
                  table_q <= '0;
`ifdef TT_GLITCH_CHECK_EN
                  unstable_q <= 1'b0;
`endif
               end
            end
            S_SETTLE: begin
               cnt_q <= cnt_q + CW'(1);
`ifdef TT_GLITCH_CHECK_EN
               if (last_settle) pre_q <= sample_in;
`endif
            end
            S_SAMPLE: begin
               // Row 0 lands in the MSB so the register reads out as the gate ID.
               table_q[~row_q[N_IN-1:0]] <= sample_in;
`ifdef TT_GLITCH_CHECK_EN
               if (sample_in != pre_q) unstable_q <= 1'b1;
`endif
               if (!last_row) begin
                  row_q <= row_q + RW'(1);
                  cnt_q <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_capture.sv
// Scoreboard bench for truth_table_capture: random truth tables are swept, the expected
// ID and done cycle are queued by the stimulus and checked by an independent monitor.
module tb_truth_table_capture;

   localparam int N   = 3;
   localparam int S   = 3;
   localparam int TW  = 8;
   localparam int LAT = TW * (S + 1);
   localparam int GK  = 2 * (S + 1) + S;

   typedef struct {
      logic [7:0] id;
      int         cyc;
      bit         gl;
   } exp_t;

   logic       clk, rst, start, sample_in, busy, done;
   logic [2:0] probe;
   logic [7:0] table_out;
   logic       start_b, sample_in_b, busy_b, done_b;
   logic [1:0] probe_b;
   logic [3:0] table_b;
`ifdef TT_GLITCH_CHECK_EN
   logic       unstable, unstable_b;
`endif

   int         cyc = 0;
   int         t0 = 0;
   bit         active = 0;
   bit         glitch_on = 0;
   logic [7:0] fval = '0;
   logic [7:0] last_id = '0;
   exp_t       q[$];
   int         checks = 0;
   int         errors = 0;

   truth_table_capture #(.N_IN(N), .SETTLE(S)) dut (
      .clk(clk), .rst(rst), .start(start), .probe(probe), .sample_in(sample_in),
      .busy(busy), .done(done), .table_out(table_out)
`ifdef TT_GLITCH_CHECK_EN
      , .unstable(unstable)
`endif
   );

   truth_table_capture #(.N_IN(2), .SETTLE(1)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .probe(probe_b), .sample_in(sample_in_b),
      .busy(busy_b), .done(done_b), .table_out(table_b)
`ifdef TT_GLITCH_CHECK_EN
      , .unstable(unstable_b)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Function under test: a lookup of the row-indexed table, optionally flipped
   // during the SAMPLE cycle of row 2 to provoke a glitch.
   always_comb begin
      sample_in = fval[probe] ^ (glitch_on && active && ((cyc - t0) == GK));
   end
   assign sample_in_b = probe_b[1] ^ probe_b[0];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   exp_t mexp;
   int   k;
   always @(negedge clk) begin
      if (active && !rst) begin
         k = cyc - t0;
         if (k < LAT) begin
            chk("probe_row", probe, k / (S + 1));
            chk("busy_in_sweep", busy, 1);
         end
      end
      if (done) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            mexp = q.pop_front();
            chk("table_out", table_out, mexp.id);
            chk("done_cycle", cyc, mexp.cyc);
            chk("busy_at_done", busy, 0);
`ifdef TT_GLITCH_CHECK_EN
            chk("unstable", unstable, mexp.gl);
`endif
         end
         active = 0;
      end
   end

   task automatic wait_done();
      for (int i = 0; i < LAT + 20; i++) begin
         @(negedge clk);
         #1;
         if (!active) return;
      end
      chk("done_timeout", 0, 1);
      active = 0;
   endtask

   task automatic launch();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      t0 = cyc;
      active = 1;
   endtask

   task automatic run_sweep(input logic [7:0] f, input bit gl, input int repulse);
      exp_t       e;
      logic [7:0] id;
      fval = f;
      glitch_on = gl;
      for (int r = 0; r < TW; r++) id[TW-1-r] = f[r] ^ (gl && (r == 2));
      launch();
      e.id  = id;
      e.cyc = t0 + LAT;
      e.gl  = gl;
      q.push_back(e);
      last_id = id;
      if (repulse > 0) begin
         do @(negedge clk); while (cyc != t0 + repulse - 1);
         start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      wait_done();
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      start_b = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_probe", probe, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_table", table_out, 0);
`ifdef TT_GLITCH_CHECK_EN
      chk("rst_unstable", unstable, 0);
`endif
      @(negedge clk);
      rst = 1'b0;

      // Ones at rows 101 and 110 -> ID 8'h06.
      run_sweep(8'h60, 0, 0);
      run_sweep(8'h00, 0, 0);
      run_sweep(8'hFF, 0, 0);
      // Re-pulsed start during the sweep is ignored.
      run_sweep(8'h60, 0, 10);

      // start arriving in FIN: ignored, result held.
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("start_in_fin_busy", busy, 0);
      chk("table_held", table_out, last_id);

      // Reset mid-sweep aborts with no done pulse.
      fval = 8'hA5;
      glitch_on = 0;
      launch();
      do @(negedge clk); while (cyc != t0 + 14);
      rst = 1'b1;
      active = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_probe", probe, 0);
      chk("abort_busy", busy, 0);
      chk("abort_table", table_out, 0);
      repeat (LAT + 5) @(negedge clk);
      chk("abort_no_done_queue", q.size(), 0);

      run_sweep(8'h60, 0, 0);
      run_sweep(8'h60, 1, 0);
      run_sweep(8'h60, 0, 0);
      for (int i = 0; i < 8; i++) begin
         run_sweep(8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)), 0);
      end

      // Two-input XOR on a SETTLE=1 instance: ID 4'h6, done 8 edges after start.
      @(negedge clk);
      start_b = 1'b1;
      @(posedge clk);
      #1;
      start_b = 1'b0;
      begin
         int tb0;
         bit seen;
         tb0 = cyc;
         seen = 0;
         for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (done_b) begin
               seen = 1;
               chk("xor_done_cycle", cyc - tb0, 8);
               chk("xor_table", table_b, 4'h6);
               chk("xor_busy_at_done", busy_b, 0);
            end
         end
         if (!seen) chk("xor_done_timeout", 0, 1);
      end

      repeat (3) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule
